// File: rtl/fugue_pkg.sv
// ---------------------------------------------------------------------------
// fugue_pkg
// Definitions shared by the Fugue sequencer slice:
//   - sequencer state encoding (fugue_seq_state_t)
//   - default word width, digest length and core handshake timeout
//   - seq_is_busy(): which states report busy to the outside world
// ---------------------------------------------------------------------------
package fugue_pkg;

    localparam int FUGUE_IOSIZE       = 16;
    localparam int FUGUE_DIGEST_WORDS = 16;
    localparam int FUGUE_TIMEOUT      = 255;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_FETCH = 3'd3,
        ST_DRAIN = 3'd4,
        ST_ERR   = 3'd5
    } fugue_seq_state_t;

    // IDLE and ERR are the only resting states; everything else is a hash
    // in progress.
    function automatic logic seq_is_busy(fugue_seq_state_t s);
        return !((s == ST_IDLE) || (s == ST_ERR));
    endfunction

endpackage

// File: rtl/fugue_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// fugue_seq_ctrl_if
// Bundles every non-clock signal of the sequencer:
//   control : start, busy, done, err
//   message : msg_valid/msg_data/msg_last/msg_ready (valid/ready, into ctrl)
//   digest  : dig_valid/dig_data/dig_ready          (valid/ready, out of ctrl)
//   core    : core_init/load/fetch/idata, core_ack/odata (to/from fugue_top)
// Modports:
//   master - the sequencer itself
//   slave  - its environment (message source, digest sink and the core)
// ---------------------------------------------------------------------------
interface fugue_seq_ctrl_if
    import fugue_pkg::*;
#(
    parameter int IOSIZE = FUGUE_IOSIZE
);
    logic              start;
    logic              busy;
    logic              done;
    logic              err;

    logic              msg_valid;
    logic [IOSIZE-1:0] msg_data;
    logic              msg_last;
    logic              msg_ready;

    logic              dig_valid;
    logic [IOSIZE-1:0] dig_data;
    logic              dig_ready;

    logic              core_init;
    logic              core_load;
    logic              core_fetch;
    logic [IOSIZE-1:0] core_idata;
    logic              core_ack;
    logic [IOSIZE-1:0] core_odata;

    modport master (
        input  start, msg_valid, msg_data, msg_last, dig_ready, core_ack, core_odata,
        output busy, done, err, msg_ready, dig_valid, dig_data,
               core_init, core_load, core_fetch, core_idata
    );

    modport slave (
        output start, msg_valid, msg_data, msg_last, dig_ready, core_ack, core_odata,
        input  busy, done, err, msg_ready, dig_valid, dig_data,
               core_init, core_load, core_fetch, core_idata
    );

endinterface

// File: rtl/fugue_wdog.sv
// ---------------------------------------------------------------------------
// fugue_wdog
// Saturating watchdog counter for the core handshake.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   run        : a request is outstanding and not acknowledged this cycle
//   clr        : restart counting (ack seen or sequencer changed state)
//   expired    : this cycle is the LIMIT-th consecutive waiting cycle
// ---------------------------------------------------------------------------
module fugue_wdog #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clr,
    output logic expired
);
    localparam int            CW       = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(LIMIT - 1);
    localparam logic [CW-1:0] SAT_CNT  = CW'(LIMIT);

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;

    // cnt_reg holds the waiting cycles already completed, so expiry is
    // flagged while the LIMIT-th one is in progress. Gating with run means
    // an ack arriving in that same cycle suppresses the expiry.
    assign expired = run && (cnt_reg >= LAST_CNT);

    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (run && (cnt_reg != SAT_CNT)) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/fugue_seq_ctrl.sv
// ---------------------------------------------------------------------------
// fugue_seq_ctrl
// Sequencer between a streaming message source and fugue_top: on start it
// inits the core, feeds it the message words through a one-entry hold
// register, fetches DIGEST_WORDS digest words and streams them out with
// backpressure. A stalled core request raises a sticky error (state ERR).
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fugue_seq_ctrl_if.master (control, message in, digest out, core)
// ---------------------------------------------------------------------------
module fugue_seq_ctrl
    import fugue_pkg::*;
#(
    parameter int IOSIZE       = FUGUE_IOSIZE,
    parameter int DIGEST_WORDS = FUGUE_DIGEST_WORDS,
    parameter int TIMEOUT      = FUGUE_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    fugue_seq_ctrl_if.master bus
);
    localparam int               CNT_W    = $clog2(DIGEST_WORDS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGEST_WORDS - 1);

    fugue_seq_state_t  state_reg;
    fugue_seq_state_t  state_next;

    logic [IOSIZE-1:0] hold_data_reg;
    logic              hold_last_reg;
    logic              hold_valid_reg;
    logic [IOSIZE-1:0] dig_data_reg;
    logic              dig_valid_reg;
    logic [CNT_W-1:0]  word_cnt_reg;
    logic              done_reg;

    logic core_load;
    logic core_fetch;
    logic msg_ready;
    logic load_xfer;
    logic msg_take;
    logic fetch_cap;
    logic dig_take;
    logic wdog_run;
    logic wdog_clr;
    logic wdog_expired;

    // Handshake strobes. msg_ready looks at core_ack so a full hold register
    // can be refilled on the very edge it drains, giving one word per cycle.
    // core_fetch looks at dig_ready so a capture can replace a word that is
    // being accepted on the same edge.
    assign core_load  = (state_reg == ST_LOAD)  && hold_valid_reg;
    assign msg_ready  = (state_reg == ST_LOAD)  && (!hold_valid_reg || bus.core_ack);
    assign core_fetch = (state_reg == ST_FETCH) && (!dig_valid_reg || bus.dig_ready);

    assign load_xfer  = core_load  && bus.core_ack;
    assign msg_take   = bus.msg_valid && msg_ready;
    assign fetch_cap  = core_fetch && bus.core_ack;
    assign dig_take   = dig_valid_reg && bus.dig_ready;

    assign wdog_run   = (core_load || core_fetch) && !bus.core_ack;
    assign wdog_clr   = bus.core_ack || (state_next != state_reg);

    fugue_wdog #(
        .LIMIT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (wdog_run),
        .clr     (wdog_clr),
        .expired (wdog_expired)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_ERR: begin
                if (bus.start) state_next = ST_INIT;
            end
            ST_INIT: begin
                state_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (wdog_expired)                    state_next = ST_ERR;
                else if (load_xfer && hold_last_reg) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (wdog_expired)                                state_next = ST_ERR;
                else if (fetch_cap && (word_cnt_reg == LAST_CNT)) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (dig_take) state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            hold_data_reg  <= '0;
            hold_last_reg  <= 1'b0;
            hold_valid_reg <= 1'b0;
            dig_data_reg   <= '0;
            dig_valid_reg  <= 1'b0;
            word_cnt_reg   <= '0;
            done_reg       <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= (state_reg == ST_DRAIN) && dig_take;

            if (state_next == ST_INIT) begin
                word_cnt_reg <= '0;
            end else if (fetch_cap) begin
                word_cnt_reg <= word_cnt_reg + 1'b1;
            end

            if (state_next == ST_ERR) begin
                // Abandon the hash: nothing stays presented to core or sink.
                hold_data_reg  <= '0;
                hold_last_reg  <= 1'b0;
                hold_valid_reg <= 1'b0;
                dig_data_reg   <= '0;
                dig_valid_reg  <= 1'b0;
            end else begin
                // The final word leaving the hold ends loading; anything
                // offered on that edge is past the end of the message.
                if (load_xfer && hold_last_reg) begin
                    hold_valid_reg <= 1'b0;
                    hold_last_reg  <= 1'b0;
                end else if (msg_take) begin
                    hold_data_reg  <= bus.msg_data;
                    hold_last_reg  <= bus.msg_last;
                    hold_valid_reg <= 1'b1;
                end else if (load_xfer) begin
                    hold_valid_reg <= 1'b0;
                end

                // A capture on the same edge as a sink accept wins, so the
                // stream keeps flowing without a bubble.
                if (fetch_cap) begin
                    dig_data_reg  <= bus.core_odata;
                    dig_valid_reg <= 1'b1;
                end else if (dig_take) begin
                    dig_valid_reg <= 1'b0;
                end
            end
        end
    end

    assign bus.busy       = seq_is_busy(state_reg);
    assign bus.done       = done_reg;
    assign bus.err        = (state_reg == ST_ERR);
    assign bus.msg_ready  = msg_ready;
    assign bus.dig_valid  = dig_valid_reg;
    assign bus.dig_data   = dig_data_reg;
    assign bus.core_init  = (state_reg == ST_INIT);
    assign bus.core_load  = core_load;
    assign bus.core_fetch = core_fetch;
    assign bus.core_idata = hold_data_reg;

endmodule
